i2c_reg_target: RTL and testbench
=================================

I2C_REG_TARGET -- requirements
Module: i2c_reg_target

Interface
REQ-001 SHALL have parameter ADDRESS, default 7'h4A, 7-bit target address matched against the address byte.
REQ-002 SHALL have parameter NUM_REGS, default 4, number of 8-bit registers (range 2..256).
REQ-003 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth on scl_i/sda_i (minimum 2).
REQ-004 SHALL have parameter AUTO_INC, default 1; 1 = pointer increments after every data byte, 0 = pointer stays fixed.
REQ-005 SHALL have port clk, input, 1, the only clock; every flop is on its rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous, active-low reset.
REQ-007 SHALL have port scl_i, input, 1, sampled SCL line.
REQ-008 SHALL have port scl_o, output, 1, SCL pull-down enable; constant 0 (no clock stretching).
REQ-009 SHALL have port sda_i, input, 1, sampled SDA line.
REQ-010 SHALL have port sda_o, output, 1, SDA pull-down enable; 1 = drive low, 0 = release.
REQ-011 SHALL have port regs_o, output, NUM_REGS*8, register file, register k at bits [8k+7:8k].
REQ-012 SHALL have port wr_strobe, output, 1, one-clk pulse when a register is written.
REQ-013 SHALL have port wr_index, output, $clog2(NUM_REGS), index of the register written, valid with wr_strobe.

Function
REQ-014 SHALL pass scl_i/sda_i through SYNC_STAGES flops, then one edge-detect flop; all decoding uses the synchronized values (clk >= 10x SCL rate required).
REQ-015 SHALL detect START as SDA falling while SCL is high, and STOP as SDA rising while SCL is high, in every state.
REQ-016 SHALL implement these states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR, WR_ACK, RD, RD_ACK, IGNORE.
REQ-017 On START (including repeated START) from any state: go to ADDR and clear the bit counter; on STOP from any state: go to IDLE and release sda_o.
REQ-018 SHALL sample data bits on SCL rising edges, MSB first, and change sda_o only on SCL falling edges.
REQ-019 ADDR: after 8 bits, if bits[7:1] == ADDRESS, drive ACK (sda_o = 1) from the next SCL fall to the following SCL fall (ADDR_ACK); otherwise go to IGNORE with sda_o = 0.
REQ-020 After ADDR_ACK: R/W = 0 -> PTR; R/W = 1 -> RD, with regs[ptr] loaded and its MSB driven at that SCL fall.
REQ-021 PTR: received byte < NUM_REGS -> load ptr, ACK, then WR; byte >= NUM_REGS -> NACK (release), then IGNORE, ptr unchanged.
REQ-022 WR: on the 8th rising edge, write the byte to regs[ptr], pulse wr_strobe for one clk with wr_index = ptr, and ACK; if AUTO_INC, ptr = (ptr+1) mod NUM_REGS.
REQ-023 RD: shift regs[ptr] out on SCL falls (sda_o = ~bit); after the 8th bit, release SDA in RD_ACK and sample master ACK on SCL rise.
REQ-024 RD_ACK: ACK (SDA low) -> ptr increments (if AUTO_INC, mod NUM_REGS) and the next byte is loaded; NACK -> IGNORE.
REQ-025 ptr SHALL persist across transactions until rewritten or reset.
REQ-026 IGNORE SHALL hold sda_o = 0 until START or STOP.
REQ-027 scl_o SHALL be 0 at all times.

Reset
REQ-028 While reset = 0: state = IDLE, ptr = 0, all regs_o = 0, sda_o = 0, scl_o = 0, wr_strobe = 0, wr_index = 0, synchronizer flops = 1 (bus idle).
REQ-029 Reset asserted mid-transfer SHALL release SDA immediately (asynchronously); after release, the block waits for a new START.

Verification
REQ-030 Write 0x94 (0x4A W), ptr 0x01, data 0xA5, STOP -> three ACKs; regs_o[15:8] = 0xA5; one wr_strobe with wr_index = 1.
REQ-031 Write 0x96 (0x4B W), 0x00 -> no ACK; sda_o stays 0; regs_o unchanged.
REQ-032 Write 0x94, ptr 0x03, data 0x11, 0x22 (NUM_REGS = 4) -> regs[3] = 0x11, regs[0] = 0x22 (wrap-around).
REQ-033 Write 0x94, ptr 0x02, repeated START, 0x95, read 2 bytes with master ACK then NACK -> returns regs[2], regs[3]; SDA released after the NACK.
REQ-034 Write 0x94, ptr 0x07 (NUM_REGS = 4) -> pointer byte NACKed; following data bytes ignored; ptr unchanged.
REQ-035 Assert reset while sda_o = 1 during an ACK -> sda_o = 0 within the same clk; regs_o = 0; the next valid transaction is ACKed normally.

Source files
------------

// File: rtl/i2c_reg_target.sv
// i2c_reg_target: I2C target exposing NUM_REGS byte registers behind a persistent register pointer
module i2c_reg_target #(
  parameter logic [6:0] ADDRESS     = 7'h4A,
  parameter int         NUM_REGS    = 4,
  parameter int         SYNC_STAGES = 2,
  parameter bit         AUTO_INC    = 1'b1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        scl_i,
  output logic                        scl_o,
  input  logic                        sda_i,
  output logic                        sda_o,
  output logic [NUM_REGS*8-1:0]       regs_o,
  output logic                        wr_strobe,
  output logic [$clog2(NUM_REGS)-1:0] wr_index
);
  localparam int IW = $clog2(NUM_REGS);
  typedef enum logic [3:0] {IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR, WR_ACK, RD, RD_ACK, IGNORE} state_t;
  state_t r_state, w_state_n;
  logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
  logic r_scl_d, r_sda_d;
  logic w_scl, w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;
  logic [3:0] r_bitcnt, w_bitcnt_n;
  logic [7:0] r_shift, w_shift_n, w_byte, w_rd_byte;
  logic [IW-1:0] r_ptr, w_ptr_n, w_ptr_inc, w_ptr_adv;
  logic r_sda, w_sda_n, r_rw, w_rw_n, w_we, w_ptr_ok;
  logic [NUM_REGS-1:0][7:0] r_regs;
  logic r_wr_strobe;
  logic [IW-1:0] r_wr_index;

  assign w_scl      = r_scl_sync[SYNC_STAGES-1];
  assign w_sda      = r_sda_sync[SYNC_STAGES-1];
  assign w_scl_rise = w_scl & ~r_scl_d;
  assign w_scl_fall = ~w_scl & r_scl_d;
  assign w_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
  assign w_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;
  assign w_byte     = {r_shift[6:0], w_sda};
  assign w_rd_byte  = r_regs[r_ptr];
  assign w_ptr_inc  = (r_ptr == IW'(NUM_REGS - 1)) ? '0 : r_ptr + IW'(1);
  assign w_ptr_adv  = AUTO_INC ? w_ptr_inc : r_ptr;
  assign w_ptr_ok   = {24'd0, w_byte} < NUM_REGS;
  assign scl_o      = 1'b0;
  assign sda_o      = r_sda;
  assign regs_o     = r_regs;
  assign wr_strobe  = r_wr_strobe;
  assign wr_index   = r_wr_index;

  // Bring the bus lines into the clk domain; flops reset to the idle-high bus level
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_i};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_i};
      r_scl_d    <= w_scl;
      r_sda_d    <= w_sda;
    end

  // Protocol state, bit counter, shift register, pointer and SDA drive
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_state  <= IDLE;
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_ptr    <= '0;
      r_sda    <= 1'b0;
      r_rw     <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_bitcnt <= w_bitcnt_n;
      r_shift  <= w_shift_n;
      r_ptr    <= w_ptr_n;
      r_sda    <= w_sda_n;
      r_rw     <= w_rw_n;
    end

  // Register file write port with a one-clk strobe per written byte
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_regs      <= '0;
      r_wr_strobe <= 1'b0;
      r_wr_index  <= '0;
    end else begin
      r_wr_strobe <= w_we;
      if (w_we) begin
        r_regs[r_ptr] <= w_byte;
        r_wr_index    <= r_ptr;
      end
    end

  // Next-state decode: bits sampled on SCL rise, SDA drive changed on SCL fall
  always_comb begin
    w_state_n  = r_state;
    w_bitcnt_n = r_bitcnt;
    w_shift_n  = r_shift;
    w_ptr_n    = r_ptr;
    w_sda_n    = r_sda;
    w_rw_n     = r_rw;
    w_we       = 1'b0;
    if (w_start) begin
      w_state_n  = ADDR;
      w_bitcnt_n = '0;
      w_sda_n    = 1'b0;
    end else if (w_stop) begin
      w_state_n = IDLE;
      w_sda_n   = 1'b0;
    end else begin
      case (r_state)
        ADDR, PTR, WR: if (w_scl_rise) begin
          w_shift_n  = w_byte;
          w_bitcnt_n = r_bitcnt + 4'd1;
          if (r_bitcnt == 4'd7) begin
            w_bitcnt_n = '0;
            if (r_state == ADDR) begin
              w_rw_n    = w_sda;
              w_state_n = (w_byte[7:1] == ADDRESS) ? ADDR_ACK : IGNORE;
            end else if (r_state == PTR) begin
              w_state_n = w_ptr_ok ? PTR_ACK : IGNORE;
              w_ptr_n   = w_ptr_ok ? w_byte[IW-1:0] : r_ptr;
            end else begin
              w_we      = 1'b1;
              w_ptr_n   = w_ptr_adv;
              w_state_n = WR_ACK;
            end
          end
        end
        ADDR_ACK, PTR_ACK, WR_ACK: if (w_scl_fall) begin
          w_sda_n = ~r_sda;
          if (r_sda) begin
            w_state_n = (r_state != ADDR_ACK) ? WR : (r_rw ? RD : PTR);
            if (r_state == ADDR_ACK && r_rw) begin
              w_shift_n = w_rd_byte;
              w_sda_n   = ~w_rd_byte[7];
            end
          end
        end
        RD: if (w_scl_rise) w_bitcnt_n = r_bitcnt + 4'd1;
        else if (w_scl_fall) begin
          if (r_bitcnt == 4'd8) begin
            w_state_n  = RD_ACK;
            w_sda_n    = 1'b0;
            w_bitcnt_n = '0;
          end else begin
            w_shift_n = {r_shift[6:0], 1'b0};
            w_sda_n   = ~r_shift[6];
          end
        end
        RD_ACK: if (w_scl_rise && r_bitcnt == 4'd0) begin
          w_state_n  = w_sda ? IGNORE : RD_ACK;
          w_ptr_n    = w_sda ? r_ptr : w_ptr_adv;
          w_bitcnt_n = 4'd1;
        end else if (w_scl_fall && r_bitcnt == 4'd1) begin
          w_state_n  = RD;
          w_bitcnt_n = '0;
          w_shift_n  = w_rd_byte;
          w_sda_n    = ~w_rd_byte[7];
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_i2c_reg_target.sv
// tb_i2c_reg_target: bus-level bench driving I2C transactions against a register-file reference model
module tb_i2c_reg_target;
  localparam int Q = 40;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;
  logic scl_o, sda_o, wr_strobe, sda_line;
  logic [31:0] regs_o;
  logic [1:0] wr_index;
  int n_chk = 0;
  int n_pass = 0;
  int stb_cnt = 0;
  int stb_idx = 0;
  int drv_cnt = 0;
  int viol = 0;
  bit mon_en = 1'b1;
  logic prev_sda = 1'b0;
  logic [7:0] m_regs [4];
  int m_ptr = 0;
  int m_nstb = 0;
  int m_idx = 0;
  logic [7:0] tx [8];

  assign sda_line = sda_m & ~sda_o;
  always #5 clk = ~clk;

  i2c_reg_target dut (
    .clk(clk), .reset(reset), .scl_i(scl_m), .scl_o(scl_o), .sda_i(sda_line), .sda_o(sda_o),
    .regs_o(regs_o), .wr_strobe(wr_strobe), .wr_index(wr_index)
  );

  // Strobe counting, SDA drive counting and SDA-changes-while-SCL-high detection
  always @(negedge clk) begin
    if (wr_strobe) begin
      stb_cnt++;
      stb_idx = wr_index;
    end
    if (sda_o) drv_cnt++;
    if (mon_en && scl_m && sda_o !== prev_sda) viol++;
    prev_sda = sda_o;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic clk_bit(input logic b, output logic s);
    sda_m = b;
    #Q scl_m = 1'b1;
    #Q s = sda_line;
    #Q scl_m = 1'b0;
    #Q;
  endtask

  task automatic bus_start();
    sda_m = 1'b1;
    #Q scl_m = 1'b1;
    #Q sda_m = 1'b0;
    #Q scl_m = 1'b0;
    #Q;
  endtask

  task automatic bus_stop();
    sda_m = 1'b0;
    #Q scl_m = 1'b1;
    #Q sda_m = 1'b1;
    #Q;
  endtask

  task automatic xfer(input logic [7:0] b, input logic ack_in, output logic [7:0] r, output logic ack_out);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(b[i], s);
      r[i] = s;
    end
    clk_bit(ack_in, ack_out);
  endtask

  task automatic wr_txn(input logic [6:0] a, input int nb, input bit stop);
    logic [7:0] r;
    logic nak;
    bit live;
    bus_start();
    xfer({a, 1'b0}, 1'b1, r, nak);
    live = (a == 7'h4A);
    check("addr_ack", 32'(!nak), 32'(live));
    for (int i = 0; i < nb; i++) begin
      xfer(tx[i], 1'b1, r, nak);
      if (i == 0) begin
        live = live && tx[0] < 8'd4;
        if (live) m_ptr = int'(tx[0]);
      end else if (live) begin
        m_regs[m_ptr] = tx[i];
        m_nstb++;
        m_idx = m_ptr;
        m_ptr = (m_ptr + 1) % 4;
      end
      check(i == 0 ? "ptr_ack" : "data_ack", 32'(!nak), 32'(live));
    end
    if (stop) bus_stop();
  endtask

  task automatic rd_txn(input logic [6:0] a, input int nb);
    logic [7:0] r;
    logic nak;
    bit live;
    bus_start();
    xfer({a, 1'b1}, 1'b1, r, nak);
    live = (a == 7'h4A);
    check("rd_addr_ack", 32'(!nak), 32'(live));
    for (int i = 0; i < nb; i++) begin
      xfer(8'hFF, i == nb - 1, r, nak);
      check("rd_data", r, live ? m_regs[m_ptr] : 8'hFF);
      if (live && i < nb - 1) m_ptr = (m_ptr + 1) % 4;
    end
    check("rd_release", sda_o, 0);
    bus_stop();
  endtask

  task automatic post();
    check("regs", regs_o, {m_regs[3], m_regs[2], m_regs[1], m_regs[0]});
    check("stb_cnt", stb_cnt, m_nstb);
    if (m_nstb > 0) check("stb_idx", stb_idx, m_idx);
    check("scl_o", scl_o, 0);
  endtask

  initial begin
    logic [7:0] ab;
    logic [6:0] a;
    logic s;
    int base, kind;
    for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
    #23;
    check("rst_sda", sda_o, 0);
    check("rst_regs", regs_o, 0);
    check("rst_stb", wr_strobe, 0);
    check("rst_idx", wr_index, 0);
    check("rst_scl", scl_o, 0);
    reset = 1'b1;
    #20;
    tx[0] = 8'h01; tx[1] = 8'hA5;
    wr_txn(7'h4A, 2, 1'b1);
    post();
    check("reg1_a5", regs_o[15:8], 8'hA5);
    base = drv_cnt;
    tx[0] = 8'h00;
    wr_txn(7'h4B, 1, 1'b1);
    check("foreign_no_drive", drv_cnt - base, 0);
    post();
    tx[0] = 8'h03; tx[1] = 8'h11; tx[2] = 8'h22;
    wr_txn(7'h4A, 3, 1'b1);
    post();
    tx[0] = 8'h02; tx[1] = 8'hC3;
    wr_txn(7'h4A, 2, 1'b1);
    tx[0] = 8'h02;
    wr_txn(7'h4A, 1, 1'b0);
    rd_txn(7'h4A, 2);
    post();
    tx[0] = 8'h07; tx[1] = 8'hAA; tx[2] = 8'hBB;
    wr_txn(7'h4A, 3, 1'b1);
    rd_txn(7'h4A, 1);
    post();
    mon_en = 1'b0;
    ab = 8'h94;
    bus_start();
    for (int i = 7; i >= 0; i--) clk_bit(ab[i], s);
    check("ack_before_rst", sda_o, 1);
    #3 reset = 1'b0;
    #1 check("rst_async_sda", sda_o, 0);
    check("rst_mid_regs", regs_o, 0);
    for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
    m_ptr = 0;
    #26 reset = 1'b1;
    bus_stop();
    mon_en = 1'b1;
    tx[0] = 8'h01; tx[1] = 8'h5A;
    wr_txn(7'h4A, 2, 1'b1);
    post();
    for (int n = 0; n < 30; n++) begin
      kind = int'($urandom_range(0, 2));
      a = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'h4A;
      for (int i = 0; i < 8; i++) tx[i] = 8'($urandom);
      tx[0] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(4, 255)) : 8'($urandom_range(0, 3));
      if (kind == 0) wr_txn(a, int'($urandom_range(0, 4)), 1'b1);
      else if (kind == 1) begin
        wr_txn(7'h4A, 1, 1'b0);
        rd_txn(a, int'($urandom_range(1, 4)));
      end else rd_txn(a, int'($urandom_range(1, 4)));
      post();
    end
    check("sda_change_scl_high", viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
